// File: rtl/bicg_pkg.sv
// Shared types and constants for the BiCG iteration controller: state encoding,
// op_start/op_done bit positions and the elaboration-time chunk count.
package bicg_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RR,
        AP,
        ALPHA,
        UPD,
        RNEW,
        TOL,
        BETA,
        PUPD,
        FIN
    } state_t;

    localparam int OP_W     = 6;
    localparam int OP_RR    = 0;
    localparam int OP_AP    = 1;
    localparam int OP_ALPHA = 2;
    localparam int OP_UPD   = 3;
    localparam int OP_RNEW  = 4;
    localparam int OP_BETA  = 5;

    // Number of memory words needed to cover n_eq complex elements.
    function automatic int chunk_count(input int n_eq, input int lanes);
        return (n_eq + lanes - 1) / lanes;
    endfunction

endpackage

// File: rtl/bicg_chunk_streamer.sv
// Issues chunk indices 0..CHUNKS-1 under a valid/ready handshake after a start pulse;
// last pulses for one cycle once the final chunk has been accepted.
module bicg_chunk_streamer #(
    parameter int CHUNKS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        rdy,
    output logic        vld,
    output logic [15:0] addr,
    output logic        last
);

    always_ff @(posedge clk) begin
        if (reset) begin
            vld  <= 1'b0;
            addr <= 16'd0;
            last <= 1'b0;
        end else begin
            last <= 1'b0;
            if (start) begin
                vld  <= 1'b1;
                addr <= 16'd0;
            end else if (vld && rdy) begin
                if (addr == 16'(CHUNKS - 1)) begin
                    vld  <= 1'b0;
                    addr <= 16'd0;
                    last <= 1'b1;
                end else begin
                    addr <= addr + 16'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bicg_iter_controller.sv
// BiCG solver iteration sequencer: launches each phase, streams chunk indices in RR/RNEW,
// and decides convergence. Optional iteration ceiling enabled by BICG_ITER_LIMIT_EN.
module bicg_iter_controller
    import bicg_pkg::*;
#(
    parameter int N_EQ     = 10,
    parameter int LANES    = 8,
    parameter int MAX_ITER = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go_i,
    input  logic [31:0]       tol_i,
    input  logic [63:0]       ratio_i,
    input  logic              ratio_vld_i,
    output logic [OP_W-1:0]   op_start_o,
    input  logic [OP_W-1:0]   op_done_i,
    output logic              rd_vld_o,
    output logic [15:0]       rd_addr_o,
    input  logic              rd_rdy_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              converged_o,
    output logic [15:0]       iter_o,
    output logic              limit_o
);

    localparam int CHUNKS = chunk_count(N_EQ, LANES);

    state_t state;
    logic   stream_start;
    logic   stream_last;
    logic   unused_ok;

    bicg_chunk_streamer #(.CHUNKS(CHUNKS)) u_stream (
        .clk   (clk),
        .reset (reset),
        .start (stream_start),
        .rdy   (rd_rdy_i),
        .vld   (rd_vld_o),
        .addr  (rd_addr_o),
        .last  (stream_last)
    );

    // Positive IEEE singles order the same as their unsigned bit patterns.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            op_start_o   <= '0;
            stream_start <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            converged_o  <= 1'b0;
            iter_o       <= 16'd0;
`ifdef BICG_ITER_LIMIT_EN
            limit_o      <= 1'b0;
`endif
        end else begin
            op_start_o   <= '0;
            stream_start <= 1'b0;
            done_o       <= 1'b0;
            case (state)
                IDLE: if (go_i) begin
                    busy_o             <= 1'b1;
                    converged_o        <= 1'b0;
                    iter_o             <= 16'd0;
`ifdef BICG_ITER_LIMIT_EN
                    limit_o            <= 1'b0;
`endif
                    op_start_o[OP_RR]  <= 1'b1;
                    stream_start       <= 1'b1;
                    state              <= RR;
                end
                RR: if (op_done_i[OP_RR]) begin
                    op_start_o[OP_AP]  <= 1'b1;
                    state              <= AP;
                end
                AP: if (op_done_i[OP_AP]) begin
                    op_start_o[OP_ALPHA] <= 1'b1;
                    state                <= ALPHA;
                end
                ALPHA: if (op_done_i[OP_ALPHA]) begin
                    op_start_o[OP_UPD] <= 1'b1;
                    state              <= UPD;
                end
                UPD: if (op_done_i[OP_UPD]) begin
                    op_start_o[OP_RNEW] <= 1'b1;
                    stream_start        <= 1'b1;
                    state               <= RNEW;
                end
                RNEW: if (op_done_i[OP_RNEW]) begin
                    state <= TOL;
                end
                TOL: if (ratio_vld_i) begin
                    if (ratio_i[63:32] <= tol_i) begin
                        converged_o <= 1'b1;
                        done_o      <= 1'b1;
                        state       <= FIN;
                    end
`ifdef BICG_ITER_LIMIT_EN
                    else if (32'(iter_o) + 32'd1 == 32'(MAX_ITER)) begin
                        limit_o <= 1'b1;
                        done_o  <= 1'b1;
                        state   <= FIN;
                    end
`endif
                    else begin
                        op_start_o[OP_BETA] <= 1'b1;
                        state               <= BETA;
                    end
                end
                BETA: if (op_done_i[OP_BETA]) begin
                    state <= PUPD;
                end
                PUPD: if (op_done_i[OP_BETA]) begin
                    if (iter_o != 16'hFFFF) iter_o <= iter_o + 16'd1;
                    op_start_o[OP_AP] <= 1'b1;
                    state             <= AP;
                end
                FIN: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef BICG_ITER_LIMIT_EN
    assign limit_o = 1'b0;
`endif

    assign unused_ok = ^{ratio_i[31:0], stream_last, 32'(MAX_ITER)};

endmodule

// File: tb/tb_bicg_iter_controller.sv
// Directed bench for bicg_iter_controller with address and completion scoreboards.
module tb_bicg_iter_controller;

    logic        clk = 1'b0;
    logic        reset, go_i, ratio_vld_i, rd_rdy_i;
    logic [31:0] tol_i;
    logic [63:0] ratio_i;
    logic [5:0]  op_done_i, op_start_o, d16_op_start;
    logic        rd_vld_o, busy_o, done_o, converged_o, limit_o;
    logic [15:0] rd_addr_o, iter_o;
    logic        d16_rd_vld, d16_busy, d16_done, d16_conv, d16_limit;
    logic [15:0] d16_rd_addr, d16_iter;

    localparam logic [31:0] TOL_V  = 32'h283424DC;
    localparam logic [31:0] HIGH_V = 32'h3F800000;
    localparam logic [31:0] LOW_V  = 32'h20000000;

    bicg_iter_controller #(.N_EQ(10), .LANES(8), .MAX_ITER(4)) dut (
        .clk(clk), .reset(reset), .go_i(go_i), .tol_i(tol_i), .ratio_i(ratio_i),
        .ratio_vld_i(ratio_vld_i), .op_start_o(op_start_o), .op_done_i(op_done_i),
        .rd_vld_o(rd_vld_o), .rd_addr_o(rd_addr_o), .rd_rdy_i(rd_rdy_i),
        .busy_o(busy_o), .done_o(done_o), .converged_o(converged_o),
        .iter_o(iter_o), .limit_o(limit_o));

    bicg_iter_controller #(.N_EQ(16), .LANES(8), .MAX_ITER(4)) dut16 (
        .clk(clk), .reset(reset), .go_i(go_i), .tol_i(tol_i), .ratio_i(ratio_i),
        .ratio_vld_i(ratio_vld_i), .op_start_o(d16_op_start), .op_done_i(op_done_i),
        .rd_vld_o(d16_rd_vld), .rd_addr_o(d16_rd_addr), .rd_rdy_i(rd_rdy_i),
        .busy_o(d16_busy), .done_o(d16_done), .converged_o(d16_conv),
        .iter_o(d16_iter), .limit_o(d16_limit));

    always #5 clk = ~clk;

    typedef struct packed {
        logic        conv;
        logic [15:0] iter;
        logic        lim;
    } cmp_t;

    cmp_t        exp_done_q[$];
    logic [15:0] exp_addr_q[$];
    logic [15:0] exp_addr16_q[$];

    int errors = 0;
    int checks = 0;
    int rr_cnt = 0, ap_cnt = 0, start_tot = 0, done_cnt = 0, acc_cnt = 0, acc16_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (op_start_o[0]) rr_cnt++;
            if (op_start_o[1]) ap_cnt++;
            if (op_start_o != 6'd0) start_tot++;
            if (rd_vld_o && rd_rdy_i) begin
                acc_cnt++;
                checks++;
                assert (exp_addr_q.size() > 0) else begin
                    errors++;
                    $error("FAIL rd_extra: observed addr %0h expected no strobe", rd_addr_o);
                end
                if (exp_addr_q.size() > 0) check("rd_addr", 32'(rd_addr_o), 32'(exp_addr_q.pop_front()));
            end
            if (d16_rd_vld && rd_rdy_i) begin
                acc16_cnt++;
                checks++;
                assert (exp_addr16_q.size() > 0) else begin
                    errors++;
                    $error("FAIL rd16_extra: observed addr %0h expected no strobe", d16_rd_addr);
                end
                if (exp_addr16_q.size() > 0) check("rd16_addr", 32'(d16_rd_addr), 32'(exp_addr16_q.pop_front()));
            end
            if (done_o) begin
                cmp_t e;
                done_cnt++;
                checks++;
                assert (exp_done_q.size() > 0) else begin
                    errors++;
                    $error("FAIL done_extra: observed done with iter %0d expected none", iter_o);
                end
                if (exp_done_q.size() > 0) begin
                    e = exp_done_q.pop_front();
                    check("done_conv", 32'(converged_o), 32'(e.conv));
                    check("done_iter", 32'(iter_o), 32'(e.iter));
                    check("done_limit", 32'(limit_o), 32'(e.lim));
                    check("d16_iter", 32'(d16_iter), 32'(e.iter));
                    check("d16_done", 32'(d16_done), 32'd1);
                end
            end
        end
    end

    task automatic wait_start(input int idx);
        int n = 0;
        while (!op_start_o[idx] && n < 40) begin
            tick();
            n++;
        end
        check($sformatf("start_%0d", idx), 32'(op_start_o[idx]), 32'd1);
    endtask

    task automatic do_phase(input int idx, input logic [5:0] stray, input bit poke_go, input bit stall);
        int s0;
        wait_start(idx);
        if (idx == 0 || idx == 4) begin
            exp_addr_q.push_back(16'd0);   exp_addr_q.push_back(16'd1);
            exp_addr16_q.push_back(16'd0); exp_addr16_q.push_back(16'd1);
        end
        tick();
        check("start_one_cycle", 32'(op_start_o), 32'd0);
        if (stall) begin
            rd_rdy_i = 1'b0;
            check("stall_vld", 32'(rd_vld_o), 32'd1);
            check("stall_addr0", 32'(rd_addr_o), 32'd0);
            tick();
            check("stall_hold", 32'(rd_addr_o), 32'd0);
            rd_rdy_i = 1'b1;
            tick();
            check("stall_addr1", 32'(rd_addr_o), 32'd1);
            tick();
            check("stall_vld_drop", 32'(rd_vld_o), 32'd0);
        end else begin
            repeat (3) tick();
            if (idx == 4) check("rnew_vld_drop", 32'(rd_vld_o), 32'd0);
        end
        if (stray != 6'd0 || poke_go) begin
            s0 = start_tot;
            op_done_i = stray;
            go_i = poke_go;
            tick();
            op_done_i = 6'd0;
            go_i = 1'b0;
            tick();
            check("stray_ignored", 32'(start_tot), 32'(s0));
        end
        op_done_i = 6'd1 << idx;
        tick();
        op_done_i = 6'd0;
    endtask

    task automatic do_tol(input logic [31:0] hi);
        ratio_i = {32'd0, 32'hFFFFFFFF};
        ratio_vld_i = 1'b0;
        tick();
        ratio_i = {hi, 32'hDEADBEEF};
        ratio_vld_i = 1'b1;
        tick();
        ratio_vld_i = 1'b0;
    endtask

    task automatic do_beta();
        do_phase(5, 6'd0, 1'b0, 1'b0);
        tick();
        op_done_i = 6'b100000;
        tick();
        op_done_i = 6'd0;
    endtask

    task automatic start_run(input logic conv, input logic [15:0] it, input logic lim);
        exp_done_q.push_back('{conv: conv, iter: it, lim: lim});
        rr_cnt = 0; ap_cnt = 0; acc_cnt = 0; acc16_cnt = 0;
        go_i = 1'b1;
        tick();
        go_i = 1'b0;
    endtask

    task automatic wait_done(input logic exp_conv);
        int n = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && n < 20) begin
            tick();
            n++;
        end
        check("done_seen", 32'(done_cnt), 32'(d0 + 1));
        repeat (3) tick();
        check("done_single", 32'(done_cnt), 32'(d0 + 1));
        check("idle_busy", 32'(busy_o), 32'd0);
        check("conv_hold", 32'(converged_o), 32'(exp_conv));
    endtask

    initial begin
        int nr;
        logic [31:0] hi;
        reset = 1'b1; go_i = 1'b0; tol_i = TOL_V; ratio_i = '0; ratio_vld_i = 1'b0;
        op_done_i = 6'd0; rd_rdy_i = 1'b1;
        repeat (3) tick();
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_op_start", 32'(op_start_o), 32'd0);
        check("rst_rd_vld", 32'(rd_vld_o), 32'd0);
        check("rst_rd_addr", 32'(rd_addr_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_conv", 32'(converged_o), 32'd0);
        check("rst_iter", 32'(iter_o), 32'd0);
        check("rst_limit", 32'(limit_o), 32'd0);
        reset = 1'b0;
        tick();

        // Run 1: ratio equal to tolerance converges on the first pass.
        start_run(1'b1, 16'd0, 1'b0);
        check("go_busy", 32'(busy_o), 32'd1);
        do_phase(0, 6'd0, 1'b0, 1'b0);
        check("rr_strobes", 32'(acc_cnt), 32'd2);
        check("rr_strobes16", 32'(acc16_cnt), 32'd2);
        do_phase(1, 6'b000100, 1'b0, 1'b0);
        do_phase(2, 6'b000010, 1'b0, 1'b0);
        do_phase(3, 6'd0, 1'b0, 1'b0);
        do_phase(4, 6'd0, 1'b0, 1'b0);
        do_tol(TOL_V);
        wait_done(1'b1);
        check("run1_iter_hold", 32'(iter_o), 32'd0);

        // Run 2: three unconverged rounds (one at tol+1), then converge; RNEW stall in round 1.
        start_run(1'b1, 16'd3, 1'b0);
        check("go_clears_conv", 32'(converged_o), 32'd0);
        check("go_clears_iter", 32'(iter_o), 32'd0);
        do_phase(0, 6'd0, 1'b0, 1'b0);
        for (int r = 0; r < 4; r++) begin
            do_phase(1, 6'd0, (r == 0), 1'b0);
            do_phase(2, 6'd0, 1'b0, 1'b0);
            do_phase(3, 6'b010000, 1'b0, 1'b0);
            do_phase(4, 6'b100000, 1'b0, (r == 1));
            hi = (r == 3) ? LOW_V : ((r == 2) ? TOL_V + 32'd1 : HIGH_V);
            do_tol(hi);
            if (r < 3) do_beta();
        end
        wait_done(1'b1);
        check("rr_once", 32'(rr_cnt), 32'd1);
        check("ap_four", 32'(ap_cnt), 32'd4);
        check("run2_iter_hold", 32'(iter_o), 32'd3);

        // Run 3: never converges; ceiling ends it when enabled.
`ifdef BICG_ITER_LIMIT_EN
        nr = 4;
        start_run(1'b0, 16'd3, 1'b1);
`else
        nr = 5;
        start_run(1'b1, 16'd4, 1'b0);
`endif
        do_phase(0, 6'd0, 1'b0, 1'b0);
        for (int r = 0; r < nr; r++) begin
            do_phase(1, 6'd0, 1'b0, 1'b0);
            do_phase(2, 6'd0, 1'b0, 1'b0);
            do_phase(3, 6'd0, 1'b0, 1'b0);
            do_phase(4, 6'd0, 1'b0, 1'b0);
`ifdef BICG_ITER_LIMIT_EN
            do_tol(HIGH_V);
`else
            do_tol((r == nr - 1) ? LOW_V : HIGH_V);
`endif
            if (r < nr - 1) do_beta();
        end
`ifdef BICG_ITER_LIMIT_EN
        wait_done(1'b0);
        check("limit_hold", 32'(limit_o), 32'd1);
`else
        wait_done(1'b1);
        check("limit_tied", 32'(limit_o), 32'd0);
`endif

        // Run 4: reset while in UPD, with a same-cycle and a following stray UPD done.
        go_i = 1'b1;
        tick();
        go_i = 1'b0;
        exp_addr_q.push_back(16'd0);   exp_addr_q.push_back(16'd1);
        exp_addr16_q.push_back(16'd0); exp_addr16_q.push_back(16'd1);
        repeat (4) tick();
        op_done_i = 6'b000001; tick(); op_done_i = 6'd0;
        do_phase(1, 6'd0, 1'b0, 1'b0);
        do_phase(2, 6'd0, 1'b0, 1'b0);
        wait_start(3);
        reset = 1'b1;
        op_done_i = 6'b001000;
        tick();
        reset = 1'b0;
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_op_start", 32'(op_start_o), 32'd0);
        check("abort_rd_vld", 32'(rd_vld_o), 32'd0);
        check("abort_done", 32'(done_o), 32'd0);
        check("abort_conv", 32'(converged_o), 32'd0);
        check("abort_iter", 32'(iter_o), 32'd0);
        check("abort_limit", 32'(limit_o), 32'd0);
        nr = start_tot + done_cnt;
        tick();
        op_done_i = 6'd0;
        repeat (5) tick();
        check("abort_stays_idle", 32'(busy_o), 32'd0);
        check("abort_no_activity", 32'(start_tot + done_cnt), 32'(nr));

        check("addr_q_empty", 32'(exp_addr_q.size() + exp_addr16_q.size()), 32'd0);
        check("done_q_empty", 32'(exp_done_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
